// File: rtl/add_sub_seq.sv
// Digit-serial two's-complement adder/subtractor.
// Processes WIDTH bits DIGIT bits per clock under a start/done handshake.
module add_sub_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dsum;
  logic             last_dig;

  assign a_dig    = opa_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign b_dig    = opb_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign dsum     = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  assign last_dig = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
          opa_d   = A;
          opb_d   = B ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d[int'(cnt_q)*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        busy_d  = 1'b1;
        if (last_dig) begin
          result_d   = acc_d;
          overflow_d = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                       (dsum[DIGIT-1] != opa_q[WIDTH-1]);
          cnt_d      = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Self-checking bench for add_sub_seq: directed cases plus random operations
// compared against an integer-arithmetic reference model.
module tb_add_sub_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] prev_res;
  logic        prev_ovf;

  add_sub_seq #(.WIDTH(16), .DIGIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: true signed arithmetic, then wrap and range-test.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] r, output logic o);
    int sa, sb, t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = s ? (sa - sb) : (sa + sb);
    r  = t[15:0];
    o  = (t > 32767) || (t < -32768);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done starting just after the accepting edge; checks result hold.
  task automatic wait_done(input string tag, output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (1) begin
      if (done) break;
      if (busy) nbusy++;
      chk({tag, "_hold"}, {15'd0, overflow, result}, {15'd0, prev_ovf, prev_res});
      if (lat >= 20) break;
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] er;
    logic        eo;
    int          lat, nb;
    model(a, b, s, er, eo);
    start = 1'b1; A = a; B = b; sub = s;
    tick();
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
    wait_done(tag, lat, nb);
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_nbusy"}, nb, 4);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, er});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    prev_res = er;
    prev_ovf = eo;
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  initial begin
    logic [15:0] er;
    logic        eo;
    int          lat, nb, ndone;

    rst = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    prev_res = '0; prev_ovf = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {28'd0, busy, done, overflow, 1'b0, result}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    do_op("add_basic", 16'h1234, 16'h0FED, 1'b0);
    do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0);
    do_op("add_neg",   16'hFFFF, 16'hFFFF, 1'b0);
    do_op("sub_ovf",   16'h8000, 16'h0001, 1'b1);
    do_op("sub_neg",   16'h0005, 16'h0009, 1'b1);
    do_op("sub_min",   16'h0000, 16'h8000, 1'b1);

    for (int i = 0; i < 24; i++) begin
      do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom));
    end

    // start pulsed during RUN must be ignored
    start = 1'b1; A = 16'h0001; B = 16'h0002; sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; A = 16'h7000; B = 16'h7000;
    tick();
    start = 1'b0;
    chk("ovl_hold", {16'd0, result}, {16'd0, prev_res});
    tick();
    chk("ovl_done", {31'd0, done}, 1);
    chk("ovl_result", {15'd0, overflow, result}, 32'h0003);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("ovl_single_done", ndone, 0);
    prev_res = 16'h0003; prev_ovf = 1'b0;

    // back-to-back with start held high
    start = 1'b1; A = 16'h4000; B = 16'h4000; sub = 1'b0;
    tick();
    A = 16'h1000; B = 16'h2345; sub = 1'b1;
    wait_done("b2b1", lat, nb);
    chk("b2b1_lat", lat, 4);
    model(16'h4000, 16'h4000, 1'b0, er, eo);
    chk("b2b1_result", {15'd0, overflow, result}, {15'd0, eo, er});
    prev_res = er; prev_ovf = eo;
    tick();
    start = 1'b0;
    chk("b2b2_busy", {31'd0, busy}, 1);
    wait_done("b2b2", lat, nb);
    chk("b2b2_period", lat + 1, 5);
    model(16'h1000, 16'h2345, 1'b1, er, eo);
    chk("b2b2_result", {15'd0, overflow, result}, {15'd0, eo, er});
    prev_res = er; prev_ovf = eo;
    tick();

    // reset in the middle of RUN
    start = 1'b1; A = 16'h1111; B = 16'h2222; sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rstrun_pre", {16'd0, result}, {16'd0, prev_res});
    rst = 1'b1;
    #1;
    chk("rstrun_outs", {28'd0, busy, done, overflow, 1'b0, result}, 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("rstrun_no_done", ndone, 0);
    prev_res = '0; prev_ovf = 1'b0;
    do_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
